multicycle_seq: RTL and testbench
=================================

Name: multicycle_seq

Overview:
- Multicycle sequencer FSM for the RISC-V core.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB states.
- Arbitrates the single shared memory port between instruction fetch and data access, using a req/ack handshake.
- Drives the datapath write enables and mux selects, counts retired instructions, and halts on illegal encodings or a memory timeout.

Parameters:
- MEM_TIMEOUT, 255: maximum number of wait cycles for mem_ack. 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- opcode  in  7  IR[6:0]; valid from DECODE onward
- funct3  in  3  IR[14:12]
- branch_taken  in  1  datapath branch comparison result
- mem_ack  in  1  memory completion strobe
- mem_req  out  1  memory request; held until acked
- mem_we  out  1  write request
- mem_be  out  4  byte enables
- addr_sel  out  1  address source: 0 = PC, 1 = ALU result
- ir_write  out  1  latch instruction register
- mdr_write  out  1  latch memory data register
- pc_write  out  1  update PC
- pc_src  out  2  next-PC source: 0 = PC+4, 1 = branch target, 2 = JAL target, 3 = JALR target
- reg_write  out  1  register file write enable
- wb_sel  out  2  write-back source: 0 = ALU, 1 = MDR, 2 = PC+4
- halted  out  1  sticky halt flag
- halt_cause  out  2  halt reason: 0 none, 1 illegal, 2 timeout
- retired  out  CNT_W  retired-instruction count
- state_dbg  out  3  current state encoding

Behaviour:
- State register is in the clk domain with asynchronous rst.
- All outputs are combinational from the current state plus opcode, funct3, branch_taken and mem_ack.
- Reset values: state = FETCH, retired = 0, halted = 0, halt_cause = 0, wait counter = 0.
  - During rst every strobe is 0: mem_req, ir_write, pc_write, reg_write, mdr_write.
  - Asserting rst mid-transaction drops mem_req immediately; the transaction is abandoned.
- FETCH:
  - mem_req = 1, mem_we = 0, addr_sel = 0, mem_be = 1111.
  - On mem_ack: ir_write = 1 in the same cycle, then go to DECODE. Otherwise stay in FETCH.
- DECODE (1 cycle):
  - Legal opcodes: LUI, AUIPC, OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR.
  - Legal LOAD funct3: 000, 001, 010, 100, 101. Legal STORE funct3: 000, 001, 010.
  - Anything else goes to HALT with halt_cause = 1. Otherwise go to EXEC.
- EXEC (1 cycle):
  - BRANCH: pc_write = 1, pc_src = branch_taken ? 1 : 0, retired += 1, go to FETCH.
  - LOAD or STORE: go to MEM.
  - All other opcodes: go to WB.
- MEM:
  - mem_req = 1, addr_sel = 1, mem_we = (STORE).
  - mem_be: 0001 for funct3 x00, 0011 for x01, 1111 for 010.
  - On ack for a STORE: pc_write = 1, pc_src = 0, retired += 1, go to FETCH.
  - On ack for a LOAD: mdr_write = 1, go to WB.
- WB (1 cycle):
  - reg_write = 1 and pc_write = 1.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - pc_src: 2 for JAL, 3 for JALR, 0 otherwise.
  - retired += 1, then go to FETCH.
- Latency with zero-wait memory:
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Handshake rules:
  - mem_req rises only on entry to FETCH or MEM and stays high until the ack cycle.
  - mem_we, mem_be and addr_sel are stable while mem_req is high.
  - mem_ack outside FETCH/MEM is ignored.
- Wait counter:
  - Clears on entry to FETCH/MEM and increments each cycle mem_req is high without ack.
  - With MEM_TIMEOUT != 0, reaching MEM_TIMEOUT goes to HALT with halt_cause = 2; mem_req drops in the HALT state.
  - An ack arriving in the same cycle the count reaches MEM_TIMEOUT wins; no timeout is raised.
- HALT:
  - Absorbing; only rst exits.
  - All strobes are 0, halted = 1, and retired is frozen.
- retired wraps modulo 2^CNT_W.
- State encoding (state_dbg): FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 7.

Decomposition:
- Shared package rv_defs holds:
  - opcode constants (OPC_LUI … OPC_JALR);
  - state encodings;
  - pc_src, wb_sel and halt_cause constants;
  - a funct3-to-byte-enable function.
- Sub-module mem_wait_timer contains the wait counter and timeout compare, with inputs clr, run, ack and output expired.
- The FSM and retired counter stay in the top module.

Test Plan:
- OP (0110011), immediate ack -> state sequence 0,1,2,4,0 over 4 cycles; one-cycle ir_write, reg_write and pc_write pulses; wb_sel = 0; retired = 1.
- LOAD funct3 = 100, data ack delayed 3 cycles -> MEM holds mem_req = 1, addr_sel = 1, mem_be = 0001 for 4 cycles; mdr_write on the ack cycle; WB gives wb_sel = 1; total 8 cycles.
- STORE funct3 = 001 -> mem_we = 1 and mem_be = 0011 in MEM; reg_write never asserted; retired increments once.
- BRANCH with branch_taken = 1, then with branch_taken = 0 -> EXEC asserts pc_write with pc_src = 1 and then 0; each branch takes 3 cycles.
- Opcode 1111111, and separately LOAD funct3 = 011 -> HALT after DECODE; halted = 1, halt_cause = 1; mem_req stays 0 for 20 or more cycles; retired is unchanged.
- MEM_TIMEOUT = 4 with no ack in FETCH -> HALT, halt_cause = 2, mem_req = 0 afterwards. Asserting rst mid-MEM gives state 0 with retired = 0, mem_req = 0 while rst is held, and mem_req re-asserted in FETCH after release.

Source files
------------

// File: rtl/multicycle_seq_pkg.sv
// Shared definitions for the multicycle sequencer: opcodes, state encodings,
// datapath select codes and small decode helpers.
package rv_defs;

  // Sequencer states; values are visible on state_dbg
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_e;

  // RV32I major opcodes handled by the sequencer
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Next-PC source select
  localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JAL    = 2'd2;
  localparam logic [1:0] PC_SRC_JALR   = 2'd3;

  // Register write-back source select
  localparam logic [1:0] WB_SEL_ALU   = 2'd0;
  localparam logic [1:0] WB_SEL_MDR   = 2'd1;
  localparam logic [1:0] WB_SEL_PC4   = 2'd2;

  // Halt reasons
  localparam logic [1:0] HALT_NONE    = 2'd0;
  localparam logic [1:0] HALT_ILLEGAL = 2'd1;
  localparam logic [1:0] HALT_TIMEOUT = 2'd2;

  // Byte enables for a data access; funct3[1:0] carries the access size
  function automatic logic [3:0] f3_to_be(input logic [2:0] f3);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001;
      2'b01:   be = 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // True for every opcode/funct3 pair the sequencer knows how to execute
  function automatic logic is_legal(input logic [6:0] opc, input logic [2:0] f3);
    logic ok;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM,
      OPC_BRANCH, OPC_JAL, OPC_JALR: ok = 1'b1;
      OPC_LOAD:  ok = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      OPC_STORE: ok = (f3 inside {3'b000, 3'b001, 3'b010});
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_seq_mem_wait_timer.sv
// Memory wait counter: counts cycles a request is outstanding without an ack
// and flags the cycle in which the count would reach TIMEOUT. An ack in that
// same cycle suppresses the flag. TIMEOUT = 0 disables expiry.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  input  logic ack,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins, otherwise advance on each unanswered request cycle
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (run && !ack) begin
      count_d = count_q + CW'(1);
    end
  end

  // Wait counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  if (TIMEOUT == 0) begin : g_no_timeout
    assign expired = 1'b0;
  end else begin : g_timeout
    // Expire in the cycle whose increment would land on TIMEOUT
    assign expired = run && !ack && (count_q == CW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/multicycle_seq.sv
// Multicycle RV32I sequencer: walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, owns the shared memory port handshake,
// drives datapath strobes and selects, counts retirements and halts on
// illegal encodings or a memory timeout.
module multicycle_seq
  import rv_defs::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             branch_taken,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic             addr_sel,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state_dbg
);

  state_e           state_q, state_d;
  logic [1:0]       halt_cause_q, halt_cause_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  logic req_c, ir_c, mdr_c, pcw_c, rw_c;
  logic timer_clr, timer_run, timer_expired;

  logic is_load, is_store;
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);

  // Next state and all datapath controls from the current state and inputs
  always_comb begin
    state_d      = state_q;
    halt_cause_d = halt_cause_q;
    req_c        = 1'b0;
    mem_we       = 1'b0;
    mem_be       = 4'b0000;
    addr_sel     = 1'b0;
    ir_c         = 1'b0;
    mdr_c        = 1'b0;
    pcw_c        = 1'b0;
    pc_src       = PC_SRC_PLUS4;
    rw_c         = 1'b0;
    wb_sel       = WB_SEL_ALU;
    retire       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        req_c  = 1'b1;
        mem_be = 4'b1111;
        if (mem_ack) begin
          ir_c    = 1'b1;
          state_d = ST_DECODE;
        end else if (timer_expired) begin
          state_d      = ST_HALT;
          halt_cause_d = HALT_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (is_legal(opcode, funct3)) begin
          state_d = ST_EXEC;
        end else begin
          state_d      = ST_HALT;
          halt_cause_d = HALT_ILLEGAL;
        end
      end
      ST_EXEC: begin
        if (opcode == OPC_BRANCH) begin
          pcw_c   = 1'b1;
          pc_src  = branch_taken ? PC_SRC_BRANCH : PC_SRC_PLUS4;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (is_load || is_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        req_c    = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_store;
        mem_be   = f3_to_be(funct3);
        if (mem_ack) begin
          if (is_store) begin
            pcw_c   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            mdr_c   = 1'b1;
            state_d = ST_WB;
          end
        end else if (timer_expired) begin
          state_d      = ST_HALT;
          halt_cause_d = HALT_TIMEOUT;
        end
      end
      ST_WB: begin
        rw_c    = 1'b1;
        pcw_c   = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
        if (is_load) begin
          wb_sel = WB_SEL_MDR;
        end else if (opcode == OPC_JAL || opcode == OPC_JALR) begin
          wb_sel = WB_SEL_PC4;
        end
        if (opcode == OPC_JAL) begin
          pc_src = PC_SRC_JAL;
        end else if (opcode == OPC_JALR) begin
          pc_src = PC_SRC_JALR;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // Wait timer restarts whenever the state changes; it only runs while requesting
  assign timer_run = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign timer_clr = (state_d != state_q);

  mem_wait_timer #(
    .TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .run     (timer_run),
    .ack     (mem_ack),
    .expired (timer_expired)
  );

  // State, halt reason and retirement counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      halt_cause_q <= HALT_NONE;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      halt_cause_q <= halt_cause_d;
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  // Strobes are forced low while reset is held so an abandoned access drops at once
  assign mem_req    = req_c & ~rst;
  assign ir_write   = ir_c  & ~rst;
  assign mdr_write  = mdr_c & ~rst;
  assign pc_write   = pcw_c & ~rst;
  assign reg_write  = rw_c  & ~rst;

  assign halted     = (state_q == ST_HALT);
  assign halt_cause = halt_cause_q;
  assign retired    = retired_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// Scoreboard bench for multicycle_seq: directed instructions push the strobe
// events they must produce; a monitor pops and compares on every strobe cycle.
module tb_multicycle_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        branch_taken;
  logic        mem_ack;
  logic        mem_req, mem_we, addr_sel, ir_write, mdr_write, pc_write, reg_write, halted;
  logic [3:0]  mem_be;
  logic [1:0]  pc_src, wb_sel, halt_cause;
  logic [31:0] retired;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  multicycle_seq #(
    .MEM_TIMEOUT(4),
    .CNT_W(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct3       (funct3),
    .branch_taken (branch_taken),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .addr_sel     (addr_sel),
    .ir_write     (ir_write),
    .mdr_write    (mdr_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .halted       (halted),
    .halt_cause   (halt_cause),
    .retired      (retired),
    .state_dbg    (state_dbg)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        ir;
    logic        mdr;
    logic        pcw;
    logic [1:0]  pcs;
    logic        rw;
    logic [1:0]  wbs;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic        as;
    logic [31:0] ret;
  } ev_t;

  typedef struct {
    string      tag;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       bt;
    int         fw;
    int         mw;
    int         path;   // 0 = via WB, 1 = load, 2 = store, 3 = branch
    logic [3:0] be;
    logic [1:0] wbs;
    logic [1:0] pcs;
  } vec_t;

  ev_t         sb_q[$];
  vec_t        vq[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_ret  = 0;
  ev_t         mon_act, mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input logic [2:0] st, input logic ir, input logic mdr,
                             input logic pcw, input logic [1:0] pcs, input logic rw,
                             input logic [1:0] wbs, input logic req, input logic we,
                             input logic [3:0] be, input logic as);
    ev_t e;
    e = '{st: st, ir: ir, mdr: mdr, pcw: pcw, pcs: pcs, rw: rw, wbs: wbs,
          req: req, we: we, be: be, as: as, ret: exp_ret};
    return e;
  endfunction

  // Monitor: every cycle with a datapath strobe must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && (ir_write || mdr_write || pc_write || reg_write)) begin
      mon_act = '{st: state_dbg, ir: ir_write, mdr: mdr_write, pcw: pc_write, pcs: pc_src,
                  rw: reg_write, wbs: wb_sel, req: mem_req, we: mem_we, be: mem_be,
                  as: addr_sel, ret: retired};
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe actual=%h required=none", mon_act);
      end else begin
        mon_exp = sb_q.pop_front();
        if (!mon_exp.req) begin
          mon_act.we = 1'b0; mon_act.be = 4'b0; mon_act.as = 1'b0;
          mon_exp.we = 1'b0; mon_exp.be = 4'b0; mon_exp.as = 1'b0;
        end
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL strobe_event actual=%h required=%h", mon_act, mon_exp);
        end
      end
    end
  end

  // One clock: drive ack, check state and mem_req mid-cycle, advance past the edge
  task automatic step(input logic ack, input int st, input int req, input string tag);
    mem_ack = ack;
    @(negedge clk);
    chk({tag, "_state"}, 32'(state_dbg), st);
    chk({tag, "_mem_req"}, 32'(mem_req), req);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
  endtask

  // One MEM-state clock with address-phase checks
  task automatic step_mem(input logic ack, input logic we, input logic [3:0] be, input string tag);
    mem_ack = ack;
    @(negedge clk);
    chk({tag, "_mem_state"}, 32'(state_dbg), 3);
    chk({tag, "_mem_req"}, 32'(mem_req), 1);
    chk({tag, "_addr_sel"}, 32'(addr_sel), 1);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'(we));
    chk({tag, "_mem_be"}, 32'(mem_be), 32'(be));
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
  endtask

  task automatic add_vec(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                         input logic bt, input int fw, input int mw, input int path,
                         input logic [3:0] be, input logic [1:0] wbs, input logic [1:0] pcs);
    vec_t v;
    v = '{tag: tag, opc: opc, f3: f3, bt: bt, fw: fw, mw: mw, path: path,
          be: be, wbs: wbs, pcs: pcs};
    vq.push_back(v);
  endtask

  // Fetch phase shared by legal and illegal instructions
  task automatic do_fetch(input int fw, input string tag);
    for (int i = 0; i < fw; i++) step(1'b0, 0, 1, {tag, "_fwait"});
    sb_q.push_back(mk(3'd0, 1, 0, 0, 2'd0, 0, 2'd0, 1, 0, 4'b1111, 0));
    step(1'b1, 0, 1, {tag, "_fetch"});
  endtask

  task automatic run_instr(input vec_t v);
    opcode = v.opc; funct3 = v.f3; branch_taken = v.bt;
    do_fetch(v.fw, v.tag);
    step(1'b1, 1, 0, {v.tag, "_decode"});          // stray ack in DECODE is ignored
    if (v.path == 3) begin
      sb_q.push_back(mk(3'd2, 0, 0, 1, v.pcs, 0, 2'd0, 0, 0, 4'b0, 0));
      step(1'b1, 2, 0, {v.tag, "_exec"});
      exp_ret++;
    end else begin
      step(1'b1, 2, 0, {v.tag, "_exec"});
      if (v.path == 1 || v.path == 2) begin
        for (int i = 0; i < v.mw; i++) step_mem(1'b0, (v.path == 2), v.be, {v.tag, "_mwait"});
        if (v.path == 2)
          sb_q.push_back(mk(3'd3, 0, 0, 1, 2'd0, 0, 2'd0, 1, 1, v.be, 1));
        else
          sb_q.push_back(mk(3'd3, 0, 1, 0, 2'd0, 0, 2'd0, 1, 0, v.be, 1));
        step_mem(1'b1, (v.path == 2), v.be, {v.tag, "_mack"});
      end
      if (v.path != 2) begin
        sb_q.push_back(mk(3'd4, 0, 0, 1, v.pcs, 1, v.wbs, 0, 0, 4'b0, 0));
        step(1'b1, 4, 0, {v.tag, "_wb"});
      end
      if (v.path == 2) exp_ret++;
      else exp_ret++;
    end
    chk({v.tag, "_retired"}, retired, exp_ret);
    $display("INSTR %-10s opcode=%b funct3=%b retired=%0d", v.tag, v.opc, v.f3, retired);
  endtask

  task automatic check_halt(input int cause, input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      mem_ack = i[0];
      @(negedge clk);
      chk({tag, "_state"}, 32'(state_dbg), 7);
      chk({tag, "_mem_req"}, 32'(mem_req), 0);
      chk({tag, "_halted"}, 32'(halted), 1);
      chk({tag, "_cause"}, 32'(halt_cause), cause);
      chk({tag, "_retired"}, retired, exp_ret);
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
    $display("HALT  %-10s cause=%0d retired=%0d", tag, halt_cause, retired);
  endtask

  task automatic reset_dut(input string tag);
    rst = 1'b1;
    @(negedge clk);
    chk({tag, "_rst_state"}, 32'(state_dbg), 0);
    chk({tag, "_rst_req"}, 32'(mem_req), 0);
    chk({tag, "_rst_retired"}, retired, 0);
    chk({tag, "_rst_halted"}, 32'(halted), 0);
    chk({tag, "_rst_cause"}, 32'(halt_cause), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_ret = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_ack = 1'b0; opcode = 7'b0; funct3 = 3'b0; branch_taken = 1'b0;
    #1;
    chk("rst_ir_write", 32'(ir_write), 0);
    chk("rst_pc_write", 32'(pc_write), 0);
    chk("rst_reg_write", 32'(reg_write), 0);
    chk("rst_mdr_write", 32'(mdr_write), 0);
    reset_dut("init");

    //       tag          opcode       f3      bt  fw mw path be       wbs   pcs
    add_vec("op_add",    7'b0110011, 3'b000, 0, 0, 0, 0, 4'b0000, 2'd0, 2'd0);
    add_vec("ld_lbu",    7'b0000011, 3'b100, 0, 0, 3, 1, 4'b0001, 2'd1, 2'd0);
    add_vec("st_sh",     7'b0100011, 3'b001, 0, 0, 0, 2, 4'b0011, 2'd0, 2'd0);
    add_vec("br_taken",  7'b1100011, 3'b000, 1, 0, 0, 3, 4'b0000, 2'd0, 2'd1);
    add_vec("br_not",    7'b1100011, 3'b001, 0, 0, 0, 3, 4'b0000, 2'd0, 2'd0);
    add_vec("jal",       7'b1101111, 3'b000, 0, 2, 0, 0, 4'b0000, 2'd2, 2'd2);
    add_vec("jalr",      7'b1100111, 3'b000, 0, 0, 0, 0, 4'b0000, 2'd2, 2'd3);
    add_vec("lui",       7'b0110111, 3'b101, 0, 1, 0, 0, 4'b0000, 2'd0, 2'd0);
    add_vec("ld_lw",     7'b0000011, 3'b010, 0, 3, 0, 1, 4'b1111, 2'd1, 2'd0);
    add_vec("st_sb",     7'b0100011, 3'b000, 0, 0, 3, 2, 4'b0001, 2'd0, 2'd0);
    add_vec("opimm",     7'b0010011, 3'b111, 0, 0, 0, 0, 4'b0000, 2'd0, 2'd0);
    add_vec("auipc",     7'b0010111, 3'b000, 0, 0, 0, 0, 4'b0000, 2'd0, 2'd0);
    add_vec("ld_lhu",    7'b0000011, 3'b101, 0, 0, 1, 1, 4'b0011, 2'd1, 2'd0);
    foreach (vq[i]) run_instr(vq[i]);

    // Reset in the middle of a data access abandons it
    opcode = 7'b0000011; funct3 = 3'b000;
    do_fetch(0, "abort");
    step(1'b0, 1, 0, "abort_decode");
    step(1'b0, 2, 0, "abort_exec");
    step_mem(1'b0, 1'b0, 4'b0001, "abort");
    #3;
    rst = 1'b1;
    #1;
    chk("abort_state", 32'(state_dbg), 0);
    chk("abort_req_in_rst", 32'(mem_req), 0);
    chk("abort_retired", retired, 0);
    @(negedge clk);
    chk("abort_req_held", 32'(mem_req), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_ret = 0;
    $display("RESET abort mid-MEM retired=%0d", retired);
    step(1'b0, 0, 1, "refetch");

    // Fetch never acked: four request cycles then timeout halt
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1, "tmo_wait");
    check_halt(2, 6, "timeout");

    // Illegal opcode after one retired instruction
    reset_dut("pre_ill");
    run_instr(vq[0]);
    opcode = 7'b1111111; funct3 = 3'b000;
    do_fetch(0, "ill_opc");
    step(1'b0, 1, 0, "ill_opc_decode");
    check_halt(1, 22, "ill_opc");

    // Illegal load width
    reset_dut("pre_ill2");
    opcode = 7'b0000011; funct3 = 3'b011;
    do_fetch(1, "ill_ld");
    step(1'b0, 1, 0, "ill_ld_decode");
    check_halt(1, 22, "ill_ld");

    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
